apb_reg_completer: RTL and testbench

//  APB completer (responder) terminating the 16-bit APB requests issued by the USB

---
 rtl/apb_reg_completer.sv | 135 +++++++++++++
 tb/tb_apb_reg_completer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/apb_reg_completer.sv
// rtl/apb_reg_completer.sv - APB completer with ID/CTRL/STATUS/W1C EVENT/TXNCNT and scratch registers
module apb_reg_completer #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          NREGS       = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [15:0] ID_VALUE    = 16'hA5C3
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [1:0]  pstrb_i,
    input  logic [31:0] paddr_i,
    input  logic [15:0] pwdata_i,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [15:0] prdata_o,
    input  logic [15:0] event_i,
    output logic [15:0] ctrl_o,
    output logic        irq_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;
    localparam int         NSCR    = NREGS - 5;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_write;
    logic [1:0]  r_strb;
    logic [15:0] r_ctrl;
    logic [15:0] r_event;
    logic [15:0] r_txncnt;
    logic [15:0] r_scratch [NSCR];
    logic [15:0] r_prdata_hold;

    logic [31:0] w_idx;
    logic        w_oob;
    logic        w_err;
    logic        w_resp;
    logic        w_commit;
    logic [15:0] w_mask;
    logic [15:0] w_clr;
    logic [15:0] w_rdata;

    assign w_idx    = r_addr - ADDR_BASE;
    assign w_oob    = (r_addr < ADDR_BASE) || (w_idx >= 32'(NREGS));
    assign w_err    = w_oob || (r_write && (w_idx == 32'd0 || w_idx == 32'd2 || w_idx == 32'd4));
    assign w_resp   = (r_state == S_RESP);
    assign w_commit = w_resp && r_write && !w_err;
    assign w_mask   = {{8{r_strb[1]}}, {8{r_strb[0]}}};
    assign w_clr    = (w_commit && w_idx == 32'd3) ? (r_wdata & w_mask) : 16'h0000;

    always_comb begin
        w_rdata = 16'h0000;
        case (w_idx)
            32'd0:   w_rdata = ID_VALUE;
            32'd1:   w_rdata = r_ctrl;
            32'd2:   w_rdata = {15'b0, |r_event};
            32'd3:   w_rdata = r_event;
            32'd4:   w_rdata = r_txncnt;
            default: begin
                for (int i = 0; i < NSCR; i++) begin
                    if (w_idx == 32'(i + 5)) w_rdata = r_scratch[i];
                end
            end
        endcase
        if (w_oob) w_rdata = 16'h0000;
    end

    assign pready_o  = w_resp;
    assign pslverr_o = w_resp && w_err;
    assign prdata_o  = w_resp ? w_rdata : r_prdata_hold;
    assign ctrl_o    = r_ctrl;
    assign irq_o     = |(r_event & r_ctrl);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_addr        <= 32'd0;
            r_wdata       <= 16'h0000;
            r_write       <= 1'b0;
            r_strb        <= 2'b00;
            r_prdata_hold <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (penable_i) begin
                        r_addr  <= paddr_i;
                        r_wdata <= pwdata_i;
                        r_write <= pwrite_i;
                        r_strb  <= pstrb_i;
                        r_cnt   <= WAIT_LD;
                        r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // penable_i is deliberately ignored here: a started transfer always completes
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) r_state <= S_RESP;
                end
                S_RESP: begin
                    r_prdata_hold <= w_rdata;
                    r_state       <= S_HOLD;
                end
                default: begin
                    if (!penable_i) r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_ctrl   <= 16'h0000;
            r_event  <= 16'h0000;
            r_txncnt <= 16'h0000;
            for (int i = 0; i < NSCR; i++) r_scratch[i] <= 16'h0000;
        end else begin
            // set beats clear when a bit is both pulsed and W1C-cleared in one cycle
            r_event <= (r_event & ~w_clr) | event_i;
            if (w_resp && !w_err) r_txncnt <= r_txncnt + 16'd1;
            if (w_commit && w_idx == 32'd1) r_ctrl <= (r_ctrl & ~w_mask) | (r_wdata & w_mask);
            for (int i = 0; i < NSCR; i++) begin
                if (w_commit && w_idx == 32'(i + 5))
                    r_scratch[i] <= (r_scratch[i] & ~w_mask) | (r_wdata & w_mask);
            end
        end
    end
endmodule

// File: tb/tb_apb_reg_completer.sv
// tb/tb_apb_reg_completer.sv - scoreboard bench for apb_reg_completer
module tb_apb_reg_completer;
    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        penable_i = 1'b0;
    logic        pwrite_i = 1'b0;
    logic [1:0]  pstrb_i = 2'b00;
    logic [31:0] paddr_i = 32'd0;
    logic [15:0] pwdata_i = 16'h0000;
    logic        pready_o;
    logic        pslverr_o;
    logic [15:0] prdata_o;
    logic [15:0] event_i = 16'h0000;
    logic [15:0] ctrl_o;
    logic        irq_o;

    typedef struct {
        logic        err;
        logic [15:0] data;
        logic        chkd;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          pulses = 0;
    logic [15:0] exp_txn = 16'h0000;

    apb_reg_completer dut (
        .pclk(pclk), .presetn(presetn), .penable_i(penable_i), .pwrite_i(pwrite_i),
        .pstrb_i(pstrb_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pready_o(pready_o),
        .pslverr_o(pslverr_o), .prdata_o(prdata_o), .event_i(event_i), .ctrl_o(ctrl_o),
        .irq_o(irq_o)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge pclk) begin
        if (presetn && pready_o) begin
            exp_t e;
            pulses++;
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pready: got pready=1 expected no response");
            end else begin
                e = q.pop_front();
                chk({e.name, "_pslverr"}, 32'(pslverr_o), 32'(e.err));
                if (e.chkd) chk({e.name, "_prdata"}, 32'(prdata_o), 32'(e.data));
            end
        end
    end

    task automatic wait_ready(input string name, input int exp_lat);
        int n = 0;
        while (!pready_o && n < 20) begin
            @(posedge pclk); #1;
            n++;
        end
        if (!pready_o) begin
            n_total++;
            $display("FAIL %s_timeout: got no pready after %0d cycles expected pready", name, n);
            void'(q.pop_back());
        end else if (exp_lat > 0) begin
            chk({name, "_latency"}, 32'(n), 32'(exp_lat));
        end
    endtask

    task automatic xfer(input string name, input logic we, input logic [31:0] addr,
                        input logic [15:0] data, input logic [1:0] strb,
                        input logic err, input logic [15:0] rd, input logic chkd);
        q.push_back('{err, rd, chkd, name});
        if (!err) exp_txn = exp_txn + 16'd1;
        @(posedge pclk); #1;
        pwrite_i = we; paddr_i = addr; pwdata_i = data; pstrb_i = strb;
        penable_i = 1'b1;
        wait_ready(name, 2);
        penable_i = 1'b0;
        @(posedge pclk); @(posedge pclk); #1;
    endtask

    initial begin
        int p0;
        #1;
        chk("rst_pready", 32'(pready_o), 0);
        chk("rst_pslverr", 32'(pslverr_o), 0);
        chk("rst_prdata", 32'(prdata_o), 0);
        chk("rst_ctrl", 32'(ctrl_o), 0);
        chk("rst_irq", 32'(irq_o), 0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;

        xfer("rd_id", 0, 0, 16'h0000, 2'b00, 0, 16'hA5C3, 1);
        xfer("wr_ctrl_lo", 1, 1, 16'h1234, 2'b01, 0, 16'h0000, 0);
        xfer("rd_ctrl", 0, 1, 16'h0000, 2'b00, 0, 16'h0034, 1);
        chk("ctrl_o_0034", 32'(ctrl_o), 32'h0034);
        xfer("wr_ctrl_nostrb", 1, 1, 16'hFFFF, 2'b00, 0, 16'h0000, 0);
        xfer("rd_ctrl_nostrb", 0, 1, 16'h0000, 2'b00, 0, 16'h0034, 1);

        xfer("wr_ctrl_1", 1, 1, 16'h0001, 2'b11, 0, 16'h0000, 0);
        @(negedge pclk) event_i = 16'h0005;
        @(negedge pclk) event_i = 16'h0000;
        chk("irq_set", 32'(irq_o), 1);
        xfer("rd_status", 0, 2, 16'h0000, 2'b00, 0, 16'h0001, 1);
        xfer("rd_event", 0, 3, 16'h0000, 2'b00, 0, 16'h0005, 1);
        event_i = 16'h0001;
        xfer("w1c_vs_set", 1, 3, 16'h0001, 2'b11, 0, 16'h0000, 0);
        event_i = 16'h0000;
        xfer("rd_event_kept", 0, 3, 16'h0000, 2'b00, 0, 16'h0005, 1);
        xfer("w1c_all", 1, 3, 16'h0005, 2'b11, 0, 16'h0000, 0);
        xfer("rd_event_clr", 0, 3, 16'h0000, 2'b00, 0, 16'h0000, 1);
        chk("irq_clr", 32'(irq_o), 0);

        xfer("rd_txn_a", 0, 4, 16'h0000, 2'b00, 0, exp_txn, 1);
        xfer("wr_txn_err", 1, 4, 16'h7777, 2'b11, 1, 16'h0000, 0);
        xfer("rd_oob_err", 0, 8, 16'h0000, 2'b00, 1, 16'h0000, 1);
        xfer("wr_id_err", 1, 0, 16'h7777, 2'b11, 1, 16'h0000, 0);
        xfer("wr_status_err", 1, 2, 16'h7777, 2'b11, 1, 16'h0000, 0);
        xfer("wr_oob_err", 1, 9, 16'h7777, 2'b11, 1, 16'h0000, 0);
        xfer("rd_txn_b", 0, 4, 16'h0000, 2'b00, 0, exp_txn, 1);
        xfer("rd_id_kept", 0, 0, 16'h0000, 2'b00, 0, 16'hA5C3, 1);
        xfer("rd_ctrl_kept", 0, 1, 16'h0000, 2'b00, 0, 16'h0001, 1);

        xfer("wr_scr7", 1, 7, 16'hBEEF, 2'b11, 0, 16'h0000, 0);
        xfer("wr_scr5_hi", 1, 5, 16'h1234, 2'b10, 0, 16'h0000, 0);
        xfer("rd_scr7", 0, 7, 16'h0000, 2'b00, 0, 16'hBEEF, 1);
        xfer("rd_scr5", 0, 5, 16'h0000, 2'b00, 0, 16'h1200, 1);

        @(negedge pclk);
        force dut.r_txncnt = 16'hFFFC;
        #1 release dut.r_txncnt;
        exp_txn = 16'hFFFC;
        xfer("pre_rd_1", 0, 0, 16'h0000, 2'b00, 0, 16'hA5C3, 1);
        xfer("pre_rd_2", 0, 0, 16'h0000, 2'b00, 0, 16'hA5C3, 1);
        xfer("rd_txn_fffe", 0, 4, 16'h0000, 2'b00, 0, 16'hFFFE, 1);
        xfer("rd_txn_ffff", 0, 4, 16'h0000, 2'b00, 0, 16'hFFFF, 1);
        xfer("rd_txn_wrap", 0, 4, 16'h0000, 2'b00, 0, 16'h0000, 1);

        q.push_back('{1'b0, 16'hA5C3, 1'b1, "drop_in_wait"});
        p0 = pulses;
        @(posedge pclk); #1;
        pwrite_i = 0; paddr_i = 0; penable_i = 1'b1;
        @(posedge pclk); #1;
        penable_i = 1'b0;
        wait_ready("drop_in_wait", 0);
        repeat (4) @(posedge pclk); #1;
        chk("drop_in_wait_pulses", 32'(pulses - p0), 1);

        p0 = pulses;
        @(posedge pclk); #1;
        pwrite_i = 0; paddr_i = 4; penable_i = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        chk("rst_mid_pready", 32'(pready_o), 0);
        chk("rst_mid_ctrl", 32'(ctrl_o), 0);
        repeat (2) @(posedge pclk);
        chk("rst_mid_no_pulse", 32'(pulses - p0), 0);
        q.push_back('{1'b0, 16'h0000, 1'b1, "post_rst_rd_txn"});
        @(negedge pclk) presetn = 1'b1;
        wait_ready("post_rst_rd_txn", 0);
        penable_i = 1'b0;
        repeat (4) @(posedge pclk); #1;
        chk("post_rst_pulses", 32'(pulses - p0), 1);
        chk("queue_empty", 32'(q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
